// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the runtime-loadable LUT neuron table writer.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic int entries_per_word(input int word_w, input int out_bits);
    return word_w / out_bits;
  endfunction

endpackage

// File: rtl/lut_dist_ram.sv
// Word-wide distributed RAM: one synchronous write port, one asynchronous read port.
module lut_dist_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_table_writer.sv
// Loads one LUT neuron truth table from a packed word stream and serves registered lookups.
module lut_neuron_table_writer
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                lut_in_valid,
  input  logic [IN_BITS-1:0]  lut_in,
  output logic                lut_out_valid,
  output logic [OUT_BITS-1:0] lut_out,
  output state_t              state
);

  localparam int EPW    = entries_per_word(WORD_W, OUT_BITS);
  localparam int NENT   = 1 << IN_BITS;
  localparam int NWORDS = (NENT + EPW - 1) / EPW;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LANE_W = (EPW > 1) ? $clog2(EPW) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);

  // Handshake: a config beat happens on a cycle where cfg_valid && cfg_ready;
  // cfg_ready is high exactly while in LOAD, and a beat coinciding with cfg_start is dropped.
  logic [WIDX_W-1:0] counter;
  logic              ram_we;
  logic [WIDX_W-1:0] rd_word;
  logic [LANE_W-1:0] rd_lane;
  logic [WORD_W-1:0] rd_data;

  assign ram_we = (state == LOAD) && cfg_valid && !cfg_start;

  always_comb begin
    rd_word = WIDX_W'(int'(lut_in) / EPW);
    rd_lane = LANE_W'(int'(lut_in) % EPW);
  end

  lut_dist_ram #(
    .DEPTH (NWORDS),
    .WIDTH (WORD_W),
    .ADDR_W(WIDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(counter),
    .wdata(cfg_data),
    .raddr(rd_word),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            loaded    <= 1'b0;
            counter   <= '0;
            cfg_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            counter <= '0;
          end else if (cfg_valid) begin
            counter <= counter + WIDX_W'(1);
            if (counter == LAST_WORD) begin
              cfg_ready <= 1'b0;
              if (cfg_last) begin
                state    <= DONE;
                cfg_done <= 1'b1;
              end else begin
                state   <= ERR;
                cfg_err <= 1'b1;
              end
            end else if (cfg_last) begin
              state     <= ERR;
              cfg_err   <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          loaded <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Lookups only see a table once a full image has landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_out_valid <= 1'b0;
      lut_out       <= '0;
    end else begin
      lut_out_valid <= lut_in_valid && loaded;
      lut_out       <= loaded ? rd_data[OUT_BITS*rd_lane +: OUT_BITS] : '0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_table_writer.sv
// Directed bench for lut_neuron_table_writer with a table model and lookup scoreboard.
module tb_lut_neuron_table_writer;
  import lut_neuron_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        cfg_done;
  logic        cfg_err;
  logic        loaded;
  logic        lut_in_valid;
  logic [7:0]  lut_in;
  logic        lut_out_valid;
  logic [1:0]  lut_out;
  state_t      state;

  int errors = 0;
  int checks = 0;

  logic [1:0] model [256];
  int         mcnt;
  logic [2:0] exp_q [$];

  lut_neuron_table_writer #(.IN_BITS(8), .OUT_BITS(2), .WORD_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .loaded       (loaded),
    .lut_in_valid (lut_in_valid),
    .lut_in       (lut_in),
    .lut_out_valid(lut_out_valid),
    .lut_out      (lut_out),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    mcnt = 0;
    check("start_ready", 32'(cfg_ready), 32'd1);
    check("start_loaded", 32'(loaded), 32'd0);
  endtask

  // One accepted beat; the model mirrors which entries it should overwrite.
  task automatic beat(input logic [31:0] data, input logic last);
    check("beat_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = data;
    cfg_last  = last;
    for (int j = 0; j < 16; j++) model[mcnt*16 + j] = data[2*j +: 2];
    mcnt++;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic random_full_load();
    for (int k = 0; k < 16; k++) beat($urandom, k == 15);
    check("rand_done", 32'(cfg_done), 32'd1);
    tick();
    check("rand_loaded", 32'(loaded), 32'd1);
  endtask

  // Back-to-back lookups; each expectation is queued when the request is driven.
  task automatic lookups(input int n, input logic is_loaded, input logic fixed, input logic [7:0] addr0);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      lut_in_valid = 1'b1;
      lut_in       = fixed ? addr0 : 8'($urandom_range(0, 255));
      exp_q.push_back(is_loaded ? {1'b1, model[lut_in]} : 3'b000);
      tick();
      e = exp_q.pop_front();
      check("lookup", {29'd0, lut_out_valid, lut_out}, {29'd0, e});
    end
    lut_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    lut_in_valid = 1'b0; lut_in = '0; mcnt = 0;
    for (int i = 0; i < 256; i++) model[i] = 2'b00;

    // 1: reset state and dropped lookup
    tick(); tick();
    rst = 1'b0;
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    lookups(1, 1'b0, 1'b1, 8'h00);

    // 2: patterned full load
    start_load();
    for (int k = 0; k < 16; k++) begin
      logic [1:0] kk;
      kk = 2'(k);
      beat({16{kk}}, k == 15);
    end
    check("p_done", 32'(cfg_done), 32'd1);
    check("p_ready_off", 32'(cfg_ready), 32'd0);
    tick();
    check("p_done_pulse", 32'(cfg_done), 32'd0);
    check("p_loaded", 32'(loaded), 32'd1);
    exp_q.push_back(3'b111);
    lut_in_valid = 1'b1; lut_in = 8'h35;
    tick();
    lut_in_valid = 1'b0;
    begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("lookup_35", {29'd0, lut_out_valid, lut_out}, {29'd0, e});
    end
    lookups(20, 1'b1, 1'b0, 8'h00);

    // 3: early cfg_last -> error
    start_load();
    for (int k = 0; k < 10; k++) beat($urandom, k == 9);
    check("early_err", 32'(cfg_err), 32'd1);
    check("early_done", 32'(cfg_done), 32'd0);
    tick();
    check("early_err_pulse", 32'(cfg_err), 32'd0);
    check("early_loaded", 32'(loaded), 32'd0);
    lookups(4, 1'b0, 1'b0, 8'h00);

    // 4: missing cfg_last -> error, extra beat refused
    start_load();
    for (int k = 0; k < 16; k++) beat($urandom, 1'b0);
    check("nolast_err", 32'(cfg_err), 32'd1);
    check("nolast_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_data = 32'hdead_beef;
    tick();
    cfg_valid = 1'b0;
    check("nolast_17_ready", 32'(cfg_ready), 32'd0);
    check("nolast_loaded", 32'(loaded), 32'd0);
    check("nolast_state", 32'(state), 32'(IDLE));

    // 5: restart mid-load; the beat alongside cfg_start must be ignored
    start_load();
    for (int k = 0; k < 7; k++) beat($urandom, 1'b0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'h1234_5678;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    mcnt = 0;
    random_full_load();
    for (int a = 0; a < 256; a += 17) lookups(1, 1'b1, 1'b1, 8'(a));
    lookups(24, 1'b1, 1'b0, 8'h00);

    // 6: reset mid-load, then a clean reload
    start_load();
    for (int k = 0; k < 5; k++) beat($urandom, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_loaded", 32'(loaded), 32'd0);
    check("rst_mid_ready", 32'(cfg_ready), 32'd0);
    lookups(2, 1'b0, 1'b0, 8'h00);
    start_load();
    random_full_load();
    lookups(24, 1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
